// File: rtl/key_event_scheduler.sv
// Debounced key front end: per-lane sync + debounce, press-to-event conversion,
// and round-robin serialization of pending presses onto one valid/ready stream.
module key_event_scheduler #(
    parameter int unsigned N_LANES         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_LANES-1:0]         key_n,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(N_LANES)-1:0] evt_lane,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int unsigned LANE_W = $clog2(N_LANES);
    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SCAN_W = LANE_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);
    localparam logic [SCAN_W-1:0] SCAN_N    = SCAN_W'(N_LANES);

    logic [N_LANES-1:0] sync_ff1;
    logic [N_LANES-1:0] sync_ff2;
    logic [N_LANES-1:0] stable;
    logic [CNT_W-1:0]   deb_cnt [N_LANES];

    logic [N_LANES-1:0] level_diff_c;
    logic [N_LANES-1:0] accept_c;
    logic [N_LANES-1:0] press_c;

    logic [N_LANES-1:0] pending;
    logic [LANE_W-1:0]  ptr;

    logic               slot_free_c;
    logic               found_c;
    logic [LANE_W-1:0]  pick_c;
    logic [SCAN_W-1:0]  scan_idx_c;
    logic [N_LANES-1:0] grant_vec_c;
    logic [N_LANES-1:0] pending_next_c;
    logic               overrun_set_c;

    // Two-flop synchronizer on the inverted (active-high) key level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff1 <= '0;
            sync_ff2 <= '0;
        end else begin
            sync_ff1 <= ~key_n;
            sync_ff2 <= sync_ff1;
        end
    end

    // A level change is accepted once it has differed from stable for DEBOUNCE_CYCLES samples.
    always_comb begin
        level_diff_c = '0;
        accept_c     = '0;
        press_c      = '0;
        for (int i = 0; i < int'(N_LANES); i++) begin
            level_diff_c[i] = sync_ff2[i] ^ stable[i];
            accept_c[i]     = level_diff_c[i] && (deb_cnt[i] == CNT_MAX);
            press_c[i]      = accept_c[i] && sync_ff2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < int'(N_LANES); i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_LANES); i++) begin
                if (!level_diff_c[i]) begin
                    deb_cnt[i] <= '0;
                end else if (accept_c[i]) begin
                    stable[i]  <= sync_ff2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Round-robin pick: first pending lane at or after ptr, wrapping modulo N_LANES.
    always_comb begin
        found_c    = 1'b0;
        pick_c     = '0;
        scan_idx_c = '0;
        for (int off = 0; off < int'(N_LANES); off++) begin
            scan_idx_c = {1'b0, ptr} + SCAN_W'(off);
            if (scan_idx_c >= SCAN_N) begin
                scan_idx_c = scan_idx_c - SCAN_N;
            end
            if (!found_c && pending[scan_idx_c[LANE_W-1:0]]) begin
                found_c = 1'b1;
                pick_c  = scan_idx_c[LANE_W-1:0];
            end
        end
    end

    always_comb begin
        slot_free_c = !evt_valid || evt_ready;
        grant_vec_c = '0;
        if (slot_free_c && found_c) begin
            grant_vec_c[pick_c] = 1'b1;
        end
        // A granted lane re-pressed in the same cycle keeps its bit without flagging loss.
        pending_next_c = (pending & ~grant_vec_c) | press_c;
        overrun_set_c  = |(press_c & pending & ~grant_vec_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            ptr       <= '0;
            evt_valid <= 1'b0;
            evt_lane  <= '0;
            overrun   <= 1'b0;
        end else begin
            pending <= pending_next_c;
            if (slot_free_c) begin
                if (found_c) begin
                    evt_valid <= 1'b1;
                    evt_lane  <= pick_c;
                    ptr       <= (pick_c == LAST_LANE) ? '0 : pick_c + LANE_W'(1);
                end else begin
                    evt_valid <= 1'b0;
                end
            end
            if (overrun_set_c) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scenario bench for key_event_scheduler: expected lanes are queued at stimulus
// time and checked against every handshake by a negedge monitor.
module tb_key_event_scheduler;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] key_n;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_lane;
    logic         overrun;
    logic         overrun_clr;

    int checks;
    int errors;
    int event_count;
    logic [1:0] exp_q[$];

    key_event_scheduler #(.N_LANES(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_lane(evt_lane),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake completes at the next posedge; compare against the oldest expected lane.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            logic [1:0] exp_lane;
            checks++;
            event_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got lane %0d, expected no event", evt_lane);
            end else begin
                exp_lane = exp_q.pop_front();
                if (evt_lane !== exp_lane) begin
                    errors++;
                    $display("FAIL scoreboard_lane: got lane %0d, expected %0d", evt_lane, exp_lane);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [1:0] lane, input logic chk_lane);
        checks++;
        if (evt_valid !== v || (chk_lane && evt_lane !== lane)) begin
            errors++;
            $display("FAIL %s: got valid=%b lane=%0d, expected valid=%b lane=%0d", name, evt_valid, evt_lane, v, lane);
        end
    endtask

    task automatic expect_drained(input string name, input int count_before, input int delta);
        checks++;
        if (exp_q.size() != 0 || event_count - count_before != delta) begin
            errors++;
            $display("FAIL %s: got %0d events with %0d still queued, expected %0d events and 0 queued",
                     name, event_count - count_before, exp_q.size(), delta);
        end
    endtask

    task automatic press_release(input logic [N-1:0] lanes);
        key_n = key_n & ~lanes;
        tick(8);
        key_n = key_n | lanes;
        tick(8);
    endtask

    task automatic test_reset;
        key_n = '1; evt_ready = 1'b1; overrun_clr = 1'b0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || evt_lane !== 2'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b lane=%0d overrun=%b, expected 0 0 0", evt_valid, evt_lane, overrun);
        end
        tick(10);
        expect_drained("reset_idle", event_count, 0);
    endtask

    task automatic test_single_press;
        int c0 = event_count;
        exp_q.push_back(2'd0);
        key_n[0] = 1'b0;
        tick(6);
        expect_out("single_before", 1'b0, 2'd0, 1'b0);
        tick(1);
        expect_out("single_rise", 1'b1, 2'd0, 1'b1);
        tick(1);
        expect_out("single_drop", 1'b0, 2'd0, 1'b0);
        tick(12);
        key_n[0] = 1'b1;
        tick(12);
        expect_drained("single_no_release_event", c0, 1);
    endtask

    task automatic test_glitch;
        int c0 = event_count;
        key_n[2] = 1'b0;
        tick(3);
        key_n[2] = 1'b1;
        tick(12);
        expect_drained("glitch_3_rejected", c0, 0);
        exp_q.push_back(2'd2);
        key_n[2] = 1'b0;
        tick(4);
        key_n[2] = 1'b1;
        tick(12);
        expect_drained("glitch_4_accepted", c0, 1);
    endtask

    task automatic test_back_to_back;
        int c0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        c0 = event_count;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        key_n = 4'b0101;
        tick(7);
        expect_out("rr_first_lane1", 1'b1, 2'd1, 1'b1);
        tick(1);
        expect_out("rr_second_lane3", 1'b1, 2'd3, 1'b1);
        tick(1);
        expect_out("rr_idle", 1'b0, 2'd0, 1'b0);
        key_n = '1;
        tick(10);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        key_n = 4'b0101;
        tick(7);
        expect_out("rr_wrap_lane1", 1'b1, 2'd1, 1'b1);
        key_n = '1;
        tick(10);
        expect_drained("rr_drained", c0, 4);
    endtask

    task automatic test_backpressure;
        int c0 = event_count;
        int held_bad = 0;
        evt_ready = 1'b0;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        key_n = 4'b1010;
        tick(7);
        expect_out("bp_first", 1'b1, 2'd0, 1'b1);
        key_n = '1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (evt_valid !== 1'b1 || evt_lane !== 2'd0) held_bad++;
        end
        checks++;
        if (held_bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d cycles not holding lane 0, expected 0", held_bad);
        end
        evt_ready = 1'b1;
        tick(1);
        expect_out("bp_second_lane2", 1'b1, 2'd2, 1'b1);
        tick(1);
        expect_out("bp_idle", 1'b0, 2'd0, 1'b0);
        expect_drained("bp_drained", c0, 2);
    endtask

    task automatic test_overrun;
        int c0 = event_count;
        evt_ready = 1'b0;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        press_release(4'b0001);
        press_release(4'b0100);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_single_press: got %b, expected 0", overrun);
        end
        press_release(4'b0100);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b, expected 1", overrun);
        end
        expect_out("overrun_slot_lane0", 1'b1, 2'd0, 1'b1);
        evt_ready = 1'b1;
        tick(5);
        expect_drained("overrun_one_lane2_event", c0, 2);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b, expected 1", overrun);
        end
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr: got %b, expected 0", overrun);
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        evt_ready = 1'b0;
        press_release(4'b0001);
        press_release(4'b1010);
        press_release(4'b0010);
        checks++;
        if (evt_valid !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset: got valid=%b overrun=%b, expected 1 1", evt_valid, overrun);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || overrun !== 1'b0 || evt_lane !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got valid=%b overrun=%b lane=%0d, expected 0 0 0", evt_valid, overrun, evt_lane);
        end
        c0 = event_count;
        evt_ready = 1'b1;
        tick(15);
        expect_drained("mid_reset_dropped", c0, 0);
    endtask

    task automatic test_held_across_reset;
        int c0 = event_count;
        key_n[1] = 1'b0;
        reset = 1'b1;
        tick(3);
        exp_q.push_back(2'd1);
        reset = 1'b0;
        tick(6);
        expect_out("held_before", 1'b0, 2'd0, 1'b0);
        tick(1);
        expect_out("held_event", 1'b1, 2'd1, 1'b1);
        tick(4);
        key_n[1] = 1'b1;
        tick(12);
        expect_drained("held_one_event", c0, 1);
    endtask

    initial begin
        checks = 0; errors = 0; event_count = 0;
        reset = 1'b1; key_n = '1; evt_ready = 1'b0; overrun_clr = 1'b0;
        tick(1);
        test_reset();
        test_single_press();
        test_glitch();
        test_back_to_back();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_held_across_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
